// File: rtl/sum_n_pkg.sv
// Shared types and width defaults for the sum-of-N accumulator front end.
package sum_n_pkg;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_SUM_W  = 7;
  localparam int DEF_CNT_W  = 4;
  localparam int MAX_N      = (1 << DEF_CNT_W) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/sum_n_accum_if.sv
// Operand/result handshake bundle between a producer and sum_n_accum.
interface sum_n_accum_if #(
  parameter int DATA_W = sum_n_pkg::DEF_DATA_W,
  parameter int SUM_W  = sum_n_pkg::DEF_SUM_W,
  parameter int CNT_W  = sum_n_pkg::DEF_CNT_W
);
  logic              start;
  logic [CNT_W-1:0]  n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [SUM_W-1:0]  sum;
  logic              sum_valid;
  logic              sum_ready;
  logic              busy;
  logic              ovf;

  modport master (
    output start, n, in_valid, in_data, sum_ready,
    input  in_ready, sum, sum_valid, busy, ovf
  );

  modport slave (
    input  start, n, in_valid, in_data, sum_ready,
    output in_ready, sum, sum_valid, busy, ovf
  );
endinterface

// File: rtl/sum_n_add.sv
// Combinational ripple adder stage: zero-extended x plus y plus cin.
module sum_n_add #(
  parameter int DATA_W = 4,
  parameter int SUM_W  = 7
) (
  input  logic [DATA_W-1:0] x,
  input  logic [SUM_W-1:0]  y,
  input  logic              cin,
  output logic [SUM_W-1:0]  s,
  output logic              cout
);
  logic [SUM_W:0] full;

  assign full      = {1'b0, y} + {{(SUM_W-DATA_W+1){1'b0}}, x} + {{SUM_W{1'b0}}, cin};
  assign {cout, s} = full;
endmodule

// File: rtl/sum_n_accum.sv
// Sequential sum-of-N front end: accumulates N operands through sum_n_add.
// Define OVERFLOW_DETECT_EN to build the sticky carry-out flag on ovf.
module sum_n_accum
  import sum_n_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SUM_W  = DEF_SUM_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic          clk,
  input logic          rst_n,
  sum_n_accum_if.slave bus
);
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  n_lat, cnt;
  logic [SUM_W-1:0]  acc, s, sum_q;
  logic              take_start, beat, last;

  assign take_start = (state == IDLE) && bus.start;
  assign beat       = (state == ACCUM) && bus.in_valid;
  assign last       = (cnt == n_lat - CNT_W'(1));

`ifdef OVERFLOW_DETECT_EN
  logic cout;
`else
  logic cout_unused;
`endif

  sum_n_add #(.DATA_W(DATA_W), .SUM_W(SUM_W)) u_add (
    .x    (bus.in_data),
    .y    (acc),
    .cin  (1'b0),
    .s    (s),
`ifdef OVERFLOW_DETECT_EN
    .cout (cout)
`else
    .cout (cout_unused)
`endif
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.n == '0) ? DONE : ACCUM;
      ACCUM:   if (bus.in_valid && last) state_nxt = DONE;
      DONE:    if (bus.sum_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == ACCUM);
    bus.sum_valid = (state == DONE);
    bus.busy      = (state != IDLE);
  end

  // sum only moves when a run completes, so it survives the return to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat <= '0;
      cnt   <= '0;
      acc   <= '0;
      sum_q <= '0;
    end else if (take_start) begin
      n_lat <= bus.n;
      cnt   <= '0;
      acc   <= '0;
      if (bus.n == '0) sum_q <= '0;
    end else if (beat) begin
      acc <= s;
      cnt <= cnt + CNT_W'(1);
      if (last) sum_q <= s;
    end
  end

  assign bus.sum = sum_q;

`ifdef OVERFLOW_DETECT_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)            ovf_q <= 1'b0;
    else if (take_start)   ovf_q <= 1'b0;
    else if (beat && cout) ovf_q <= 1'b1;

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_sum_n_accum.sv
// Directed + randomized self-checking bench for sum_n_accum.
module tb_sum_n_accum;
  import sum_n_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int SW = DEF_SUM_W;
  localparam int CW = DEF_CNT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ops[16];

  sum_n_accum_if #(.DATA_W(DW), .SUM_W(SW), .CNT_W(CW)) bus ();

  sum_n_accum #(.DATA_W(DW), .SUM_W(SW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete run: start, nn operands from ops[], gap idle cycles between
  // beats, rdly cycles of back-pressure on the result. Expected values come
  // from the plain arithmetic total of the operands.
  task automatic run(input int nn, input int gap, input int rdly, input string tag);
    int  tot;
    int  es;
    bit  eo;
    tot = 0;
    for (int i = 0; i < nn; i++) tot += ops[i];
    es = tot % (1 << SW);
`ifdef OVERFLOW_DETECT_EN
    eo = (tot >= (1 << SW));
`else
    eo = 1'b0;
`endif
    bus.start = 1'b1;
    bus.n     = CW'(nn);
    tick();
    bus.start = 1'b0;
    chk({tag, ":busy_after_start"}, bus.busy, 1);
    for (int i = 0; i < nn; i++) begin
      chk({tag, ":in_ready"}, bus.in_ready, 1);
      chk({tag, ":no_early_valid"}, bus.sum_valid, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(ops[i]);
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = DW'($urandom);
      if (i != nn - 1)
        repeat (gap) begin
          bus.start = 1'b1;
          bus.n     = CW'($urandom);
          tick();
          bus.start = 1'b0;
        end
    end
    chk({tag, ":sum_valid"}, bus.sum_valid, 1);
    chk({tag, ":sum"}, bus.sum, es);
    chk({tag, ":ovf"}, bus.ovf, eo);
    chk({tag, ":in_ready_done"}, bus.in_ready, 0);
    repeat (rdly) begin
      bus.start = 1'b1;
      bus.n     = CW'($urandom);
      tick();
      bus.start = 1'b0;
      chk({tag, ":held_valid"}, bus.sum_valid, 1);
      chk({tag, ":held_sum"}, bus.sum, es);
    end
    bus.sum_ready = 1'b1;
    tick();
    bus.sum_ready = 1'b0;
    chk({tag, ":valid_drop"}, bus.sum_valid, 0);
    chk({tag, ":sum_kept"}, bus.sum, es);
    chk({tag, ":idle"}, bus.busy, 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.n         = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.sum_ready = 1'b0;

    #2;
    chk("rst:sum", bus.sum, 0);
    chk("rst:sum_valid", bus.sum_valid, 0);
    chk("rst:in_ready", bus.in_ready, 0);
    chk("rst:busy", bus.busy, 0);
    chk("rst:ovf", bus.ovf, 0);
    #20 rst_n = 1'b1;
    tick();

    ops[0] = 5; ops[1] = 7; ops[2] = 9;
    run(3, 0, 0, "n3");

    run(0, 0, 0, "n0");
    chk("n0:in_ready_after", bus.in_ready, 0);

    for (int i = 0; i < 15; i++) ops[i] = 15;
    run(15, 0, 0, "n15");

    ops[0] = 15;
    run(1, 0, 0, "b2b");

    ops[0] = 1; ops[1] = 2; ops[2] = 3; ops[3] = 4;
    run(4, 2, 5, "gaps");

    // abort a run mid-way with reset; nothing may leak into the next run
    bus.start = 1'b1;
    bus.n     = CW'(5);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(15);
      tick();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst:busy", bus.busy, 0);
    chk("mid_rst:in_ready", bus.in_ready, 0);
    chk("mid_rst:sum_valid", bus.sum_valid, 0);
    chk("mid_rst:sum", bus.sum, 0);
    chk("mid_rst:ovf", bus.ovf, 0);
    #12 rst_n = 1'b1;
    tick();
    ops[0] = 6; ops[1] = 6;
    run(2, 0, 0, "post_rst");

    for (int r = 0; r < 12; r++) begin
      int nn;
      nn = $urandom_range(MAX_N, 1);
      for (int i = 0; i < nn; i++) ops[i] = $urandom_range((1 << DW) - 1, 0);
      run(nn, $urandom_range(2, 0), $urandom_range(3, 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sum_n_accum.md
# sum_n_accum

Sequential front end for the sum-of-N datapath. It accepts a stream of N unsigned 4-bit operands over a valid/ready handshake and drives each operand plus the registered running sum through the 4+7-bit ripple adder stage. It returns the 7-bit total through a valid/ready result handshake. It sits directly upstream of the adder, supplying its x, y and cin and consuming its s and cout.

## Interface
- DATA_W, 4, operand width (adder x width)
- SUM_W, 7, accumulator/result width (adder y/s width)
- CNT_W, 4, width of operand count N (max N = 2^CNT_W-1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  begin a new sum; sampled only in IDLE
- n  in  CNT_W  operand count, latched on accepted start
- in_valid  in  1  operand present
- in_data  in  DATA_W  unsigned operand
- in_ready  out  1  high only in ACCUM
- sum  out  SUM_W  registered total, modulo 2^SUM_W
- sum_valid  out  1  high in DONE
- sum_ready  in  1  consumer accepts sum
- busy  out  1  high whenever state != IDLE
- ovf  out  1  sticky carry-out flag (see Configuration)

## Operation
- States: IDLE, ACCUM, DONE (2-bit encoding).
- IDLE, start=1: latch n; clear acc, cnt and ovf. If n==0, go to DONE with sum=0; otherwise go to ACCUM. start=0 stays in IDLE.
- ACCUM: in_ready=1. An operand beat is accepted when in_valid&in_ready. On each beat:
  - acc <= s, where s is the adder output for x=in_data, y=acc, cin=0 (wraps mod 128).
  - cnt <= cnt+1.
  - If cnt==n_lat-1, go to DONE.
- ACCUM with in_valid low: hold acc and cnt; no timeout.
- DONE: sum_valid=1 and sum=acc, both held stable until sum_ready=1. On the handshake edge, go to IDLE; sum keeps its value and sum_valid drops.
- start is ignored in ACCUM and DONE. n is not re-sampled until the next start taken in IDLE.
- Reset (any state, any cycle): state=IDLE, acc=0, cnt=0, sum=0, sum_valid=0, in_ready=0, busy=0, ovf=0. A partial sum is discarded and is not resumed.

## Timing
- start taken at edge 0 puts ACCUM at edge 1; in_ready is high from cycle 1.
- One operand per cycle at most. The last beat accepted at edge k gives sum_valid=1 after edge k.
- Minimum latency from start to sum_valid is N+1 cycles. For n==0 it is 1 cycle.
- sum_valid together with sum_ready at edge m gives IDLE after m. A new start can be taken at edge m+1 at the earliest.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or sum_ready to any output.

## Configuration
- OVERFLOW_DETECT_EN defined: ovf is set on any accepted beat where adder cout=1. ovf is sticky until the next accepted start or reset, and is valid alongside sum_valid.
- OVERFLOW_DETECT_EN undefined: the ovf port remains, tied to 0. cout is left unused and no ovf flop is built. Sum wrap behaviour is identical in both builds.

## Structure
- Package sum_n_pkg holds:
  - the state enum (IDLE, ACCUM, DONE)
  - DATA_W/SUM_W/CNT_W defaults
  - localparam MAX_N = 2^CNT_W-1
- One sub-module, sum_n_add: the combinational adder (x[DATA_W], y[SUM_W], cin → s[SUM_W], cout). It is instantiated once with cin=0. Its x input is zero-extended internally.

## Test plan
- n=3, operands 5, 7, 9 back-to-back, sum_ready=1 → sum=21, sum_valid for 1 cycle 4 cycles after start, ovf=0.
- n=0, start pulse → sum=0 and sum_valid one cycle after start. in_ready never rises.
- n=15, all operands 15 → sum=97 (225 mod 128). ovf=1 with OVERFLOW_DETECT_EN, ovf=0 without it.
- n=4, operands 1, 2, 3, 4 with in_valid low for 2 cycles between each beat and sum_ready held low for 5 cycles → sum=10 held stable with sum_valid high the whole time. start pulses during ACCUM/DONE have no effect.
- n=5, rst_n asserted after 2 beats → all outputs 0 immediately. A new start with n=2 and operands 6, 6 gives sum=12 with no residue from before the reset.
- Back-to-back runs: sum_ready handshake, then start on the next cycle with n=1 and operand 15 → sum=15. ovf from the previous run is cleared.
